// File: rtl/mull_pkg.sv
// Shared definitions for the multiply-long writeback stage.
// Holds the writeback FSM state encoding, the ALU op-code constants and a
// helper that classifies an op code as a two-write (long) multiply.
package mull_pkg;

    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_SMULL = 3'b110;
    localparam logic [2:0] OP_UMULL = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWrLo = 2'd1,
        StWrHi = 2'd2
    } state_e;

    // Long ops produce a 64-bit product and need two register-file writes.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_SMULL) || (op == OP_UMULL);
    endfunction

endpackage

// File: rtl/mull_flag_gen.sv
// N/Z flag generator for multiply results (used only when MULL_FLAGS_EN is defined).
// Ports:
//   value_i   [2*DATA_W-1:0]  {high half, low half} of the result
//   is_long_i                 1 = judge the full 64-bit product, 0 = low half only
//   n_o, z_o                  negative / zero flags
module mull_flag_gen #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] value_i,
    input  logic                is_long_i,
    output logic                n_o,
    output logic                z_o
);

    always_comb begin
        if (is_long_i) begin
            n_o = value_i[2*DATA_W-1];
            z_o = (value_i == '0);
        end else begin
            n_o = value_i[DATA_W-1];
            z_o = (value_i[DATA_W-1:0] == '0);
        end
    end

endmodule

// File: rtl/mull_writeback.sv
// Writeback stage for MUL / SMULL / UMULL results through a single register-file
// write port. Single-write ops take one write cycle; long ops take two (low half to
// RdLo, then high half to RdHi). A new bundle can be accepted in the final write
// cycle of the current op, so there is no bubble between ops.
// Optional feature: define MULL_FLAGS_EN to derive N/Z from the result itself
// instead of taking them from ALUFlags.
// Ports:
//   clk, reset (async, active low)
//   in_valid / in_ready         bundle handshake; Stall = in_valid & ~in_ready
//   ALUControl, Result, ResultExtra, ALUFlags, SetFlags, RdLo, RdHi   bundle
//   RegWrite, WA3, WD3          register-file write port (registered)
//   Flags                       registered NZCV
module mull_writeback
    import mull_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ALUControl,
    input  logic [DATA_W-1:0] Result,
    input  logic [DATA_W-1:0] ResultExtra,
    input  logic [3:0]        ALUFlags,
    input  logic              SetFlags,
    input  logic [ADDR_W-1:0] RdLo,
    input  logic [ADDR_W-1:0] RdHi,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WA3,
    output logic [DATA_W-1:0] WD3,
    output logic [3:0]        Flags,
    output logic              Stall
);

    state_e            state_q, state_d;
    logic              long_q, long_d;
    logic              set_flags_q, set_flags_d;
    logic [1:0]        alu_nz_q, alu_nz_d;
    logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
    logic [DATA_W-1:0] lo_data_q, lo_data_d;
    logic [DATA_W-1:0] hi_data_q, hi_data_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] wa3_q, wa3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic [3:0]        flags_q, flags_d;

    logic              accept;
    logic              final_cycle;
    logic [1:0]        nz_src;
    logic              unused_inputs;

`ifdef MULL_FLAGS_EN
    logic gen_n, gen_z;

    mull_flag_gen #(
        .DATA_W(DATA_W)
    ) u_flag_gen (
        .value_i  ({hi_data_q, lo_data_q}),
        .is_long_i(long_q),
        .n_o      (gen_n),
        .z_o      (gen_z)
    );

    assign nz_src        = {gen_n, gen_z};
    assign unused_inputs = ^{ALUFlags[1:0], alu_nz_q};
`else
    assign nz_src        = alu_nz_q;
    assign unused_inputs = ^ALUFlags[1:0];
`endif

    // Ready in IDLE and in the last write cycle of the op in flight.
    assign final_cycle = ((state_q == StWrLo) && !long_q) || (state_q == StWrHi);
    assign in_ready    = (state_q == StIdle) || final_cycle;
    assign accept      = in_valid && in_ready;
    assign Stall       = in_valid && !in_ready;

    assign RegWrite = reg_write_q;
    assign WA3      = wa3_q;
    assign WD3      = wd3_q;
    assign Flags    = flags_q;

    always_comb begin
        state_d     = state_q;
        long_d      = long_q;
        set_flags_d = set_flags_q;
        alu_nz_d    = alu_nz_q;
        hi_addr_d   = hi_addr_q;
        lo_data_d   = lo_data_q;
        hi_data_d   = hi_data_q;
        reg_write_d = 1'b0;
        wa3_d       = '0;
        wd3_d       = '0;
        flags_d     = flags_q;

        // Second write of a long op is set up while the first is on the port.
        if ((state_q == StWrLo) && long_q) begin
            state_d     = StWrHi;
            reg_write_d = 1'b1;
            wa3_d       = hi_addr_q;
            wd3_d       = hi_data_q;
        end else if (final_cycle) begin
            state_d = StIdle;
        end

        // C and V are never touched here.
        if (final_cycle && set_flags_q) begin
            flags_d = {nz_src, flags_q[1:0]};
        end

        if (accept) begin
            state_d     = StWrLo;
            long_d      = is_long_op(ALUControl);
            set_flags_d = SetFlags;
            alu_nz_d    = ALUFlags[3:2];
            hi_addr_d   = RdHi;
            lo_data_d   = Result;
            hi_data_d   = ResultExtra;
            reg_write_d = 1'b1;
            wa3_d       = RdLo;
            wd3_d       = Result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            long_q      <= 1'b0;
            set_flags_q <= 1'b0;
            alu_nz_q    <= 2'b00;
            hi_addr_q   <= '0;
            lo_data_q   <= '0;
            hi_data_q   <= '0;
            reg_write_q <= 1'b0;
            wa3_q       <= '0;
            wd3_q       <= '0;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            set_flags_q <= set_flags_d;
            alu_nz_q    <= alu_nz_d;
            hi_addr_q   <= hi_addr_d;
            lo_data_q   <= lo_data_d;
            hi_data_q   <= hi_data_d;
            reg_write_q <= reg_write_d;
            wa3_q       <= wa3_d;
            wd3_q       <= wd3_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_mull_writeback.sv
// Self-checking bench for mull_writeback: expected register writes are queued as
// bundles are accepted and checked in order as the write port produces them.
module tb_mull_writeback;
    import mull_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    ALUControl;
    logic [DW-1:0] Result;
    logic [DW-1:0] ResultExtra;
    logic [3:0]    ALUFlags;
    logic          SetFlags;
    logic [AW-1:0] RdLo;
    logic [AW-1:0] RdHi;
    logic          RegWrite;
    logic [AW-1:0] WA3;
    logic [DW-1:0] WD3;
    logic [3:0]    Flags;
    logic          Stall;

    mull_writeback #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .Result     (Result),
        .ResultExtra(ResultExtra),
        .ALUFlags   (ALUFlags),
        .SetFlags   (SetFlags),
        .RdLo       (RdLo),
        .RdHi       (RdHi),
        .RegWrite   (RegWrite),
        .WA3        (WA3),
        .WD3        (WD3),
        .Flags      (Flags),
        .Stall      (Stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_e;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] exp_flags = 4'b0000;

    // Write-port monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            n_cmp++;
            if (RegWrite === 1'b1) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write got r%0d=%h required no write", WA3, WD3);
                end else begin
                    mon_e = sb.pop_front();
                    if (WA3 !== mon_e.a || WD3 !== mon_e.d) begin
                        n_err++;
                        $display("FAIL write_data got r%0d=%h required r%0d=%h",
                                 WA3, WD3, mon_e.a, mon_e.d);
                    end
                end
            end else if (RegWrite !== 1'b0 || WA3 !== '0 || WD3 !== '0) begin
                n_err++;
                $display("FAIL idle_port got we=%b r%0d=%h required we=0 r0=0", RegWrite, WA3, WD3);
            end
        end
    end

    function automatic logic [3:0] model_flags(input logic [2:0] op, input logic [DW-1:0] lo,
                                               input logic [DW-1:0] hi, input logic [3:0] af,
                                               input logic [3:0] old);
        logic n, z;
`ifdef MULL_FLAGS_EN
        if (is_long_op(op)) begin
            n = hi[DW-1];
            z = ({hi, lo} == '0);
        end else begin
            n = lo[DW-1];
            z = (lo == '0);
        end
`else
        n = af[3];
        z = af[2];
`endif
        return {n, z, old[1:0]};
    endfunction

    // Present a bundle (called at posedge+#1) and hold it until accepted.
    task automatic send(input logic [2:0] op, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                        input logic [AW-1:0] rl, input logic [AW-1:0] rh, input logic sf,
                        input logic [3:0] af, input int exp_wait);
        int waits = 0;
        ALUControl  = op;
        Result      = lo;
        ResultExtra = hi;
        RdLo        = rl;
        RdHi        = rh;
        SetFlags    = sf;
        ALUFlags    = af;
        in_valid    = 1'b1;
        while (in_ready !== 1'b1 && waits < 10) begin
            n_cmp++;
            if (Stall !== 1'b1) begin
                n_err++;
                $display("FAIL stall_high got %b required 1", Stall);
            end
            @(posedge clk);
            #1;
            waits++;
        end
        n_cmp++;
        if (waits != exp_wait || Stall !== 1'b0) begin
            n_err++;
            $display("FAIL accept_wait got %0d cycles stall=%b required %0d cycles stall=0",
                     waits, Stall, exp_wait);
        end
        if (waits >= 10) return;
        sb.push_back('{a: rl, d: lo});
        if (is_long_op(op)) sb.push_back('{a: rh, d: hi});
        if (sf) exp_flags = model_flags(op, lo, hi, af, exp_flags);
        @(posedge clk);
        #1;
        n_cmp++;
        if (RegWrite !== 1'b1 || WA3 !== rl || WD3 !== lo) begin
            n_err++;
            $display("FAIL first_write_latency got we=%b r%0d=%h required we=1 r%0d=%h",
                     RegWrite, WA3, WD3, rl, lo);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 30; k++) begin
            if (sb.size() == 0 && RegWrite === 1'b0) break;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (k >= 30 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_drain got pending=%0d ready=%b required pending=0 ready=1",
                     name, sb.size(), in_ready);
        end
        n_cmp++;
        if (Flags !== exp_flags) begin
            n_err++;
            $display("FAIL %s_flags got %b required %b", name, Flags, exp_flags);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (RegWrite !== 1'b0 || WA3 !== '0 || WD3 !== '0 || Flags !== 4'b0000 ||
            in_ready !== 1'b1 || Stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got we=%b wa=%h wd=%h fl=%b rdy=%b st=%b required 0 0 0 0000 1 0",
                     RegWrite, WA3, WD3, Flags, in_ready, Stall);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        send(OP_MUL, 32'hFFFF_FFFA, 32'h0, 4'd3, 4'd0, 1'b1, 4'b1000, 0);
        idle();
        drain("mul");
    endtask

    // SMULL with a MUL held behind it: stalls in WR_LO, accepted in WR_HI.
    task automatic test_smull_back_to_back();
        send(OP_SMULL, 32'hFFFF_FFCE, 32'hFFFF_FFFF, 4'd1, 4'd2, 1'b1, 4'b1000, 0);
        send(OP_MUL, 32'h0000_002A, 32'h0, 4'd7, 4'd0, 1'b0, 4'b0000, 1);
        idle();
        drain("smull_b2b");
    endtask

    task automatic test_umull();
        send(OP_UMULL, 32'h0000_01C2, 32'h0, 4'd4, 4'd6, 1'b1, 4'b0000, 0);
        idle();
        drain("umull");
    endtask

    task automatic test_same_rd();
        send(OP_UMULL, 32'h1234_5678, 32'h0000_0007, 4'd5, 4'd5, 1'b1, 4'b0000, 0);
        idle();
        drain("same_rd");
    endtask

    // Single-write ops every cycle; the last one produces a zero result.
    task automatic test_single_stream();
        logic [DW-1:0] lo;
        for (int i = 0; i < 6; i++) begin
            lo = (i == 5) ? 32'h0 : DW'($urandom);
            send((i % 2 == 0) ? 3'b000 : OP_MUL, lo, DW'($urandom), AW'(i + 8), AW'(i),
                 (i >= 4), {lo[DW-1], lo == '0, 2'b00}, 0);
        end
        idle();
        drain("single_stream");
    endtask

    task automatic test_setflags_hold();
        send(OP_MUL, 32'h8000_0000, 32'h0, 4'd9, 4'd0, 1'b0, 4'b1000, 0);
        idle();
        drain("flags_hold");
        send(OP_MUL, 32'h8000_0000, 32'h0, 4'd9, 4'd0, 1'b1, 4'b1000, 0);
        idle();
        drain("flags_set");
    endtask

    // Reset in WR_LO of a long op: the high write must never appear.
    task automatic test_reset_abort();
        send(OP_SMULL, 32'hAAAA_0001, 32'h5555_0002, 4'd10, 4'd11, 1'b1, 4'b1000, 0);
        idle();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (RegWrite !== 1'b0 || WA3 !== '0 || WD3 !== '0 || Flags !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_abort got we=%b wa=%h wd=%h fl=%b required 0 0 0 0000",
                     RegWrite, WA3, WD3, Flags);
        end
        sb.delete();
        exp_flags = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset got %b required 1", in_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        drain("reset_abort");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid    = 1'b0;
        ALUControl  = 3'b000;
        Result      = '0;
        ResultExtra = '0;
        ALUFlags    = 4'b0000;
        SetFlags    = 1'b0;
        RdLo        = '0;
        RdHi        = '0;
        test_reset();
        test_mul();
        test_smull_back_to_back();
        test_umull();
        test_same_rd();
        test_single_stream();
        test_setflags_hold();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mull_writeback.md
MULL_WRITEBACK -- requirements
Module: mull_writeback

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of each result half and of the write-data port.
REQ-002 Parameter ADDR_W, default 4, SHALL set the register-file address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark that the ALU-stage result bundle is valid.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a bundle this cycle.
REQ-007 ALUControl  input  3  SHALL carry the ALU op code: MUL=100, SMULL=110, UMULL=111; any other value is a single-write op.
REQ-008 Result  input  DATA_W  SHALL carry the lower 32 bits of the ALU result.
REQ-009 ResultExtra  input  DATA_W  SHALL carry the upper 32 bits for SMULL/UMULL and is ignored otherwise.
REQ-010 ALUFlags  input  4  SHALL carry the ALU NZCV flags.
REQ-011 SetFlags  input  1  SHALL request a flag update for this op.
REQ-012 RdLo, RdHi  input  ADDR_W each  SHALL give the destination registers for the low and high halves; single-write ops use RdLo.
REQ-013 RegWrite  output  1, WA3  output  ADDR_W, WD3  output  DATA_W  SHALL form the single register-file write port.
REQ-014 Flags  output  4  SHALL be the registered NZCV state.
REQ-015 Stall  output  1  SHALL equal in_valid AND NOT in_ready.

Function
REQ-016 FSM states: IDLE, WR_LO, WR_HI; acceptance occurs when in_valid and in_ready are both high, capturing all inputs.
REQ-017 On acceptance, the next state SHALL be WR_LO, and the bundle's long-op bit SHALL be set to (ALUControl == 110 or 111).
REQ-018 In WR_LO: RegWrite=1, WA3=captured RdLo, WD3=captured Result; next state WR_HI if long, else IDLE (or WR_LO again on a same-cycle acceptance).
REQ-019 In WR_HI: RegWrite=1, WA3=captured RdHi, WD3=captured ResultExtra; next state IDLE, or WR_LO on a same-cycle acceptance.
REQ-020 in_ready SHALL be high in IDLE and in the final write cycle of an op (WR_LO of a single-write op, WR_HI of a long op), and low otherwise.
REQ-021 Latency: the first write SHALL occur exactly one cycle after acceptance; throughput is 1 op/cycle for single-write ops and 1 op/2 cycles for long ops.
REQ-022 In IDLE, RegWrite SHALL be 0, and WA3/WD3 SHALL be 0.
REQ-023 If RdLo == RdHi, both writes SHALL still occur in order, so the high half is the final value.
REQ-024 Flags SHALL update only in the final write cycle of an op whose captured SetFlags=1; otherwise Flags SHALL hold.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, RegWrite=0, WA3=0, WD3=0, and Flags=0000.
REQ-026 Reset during WR_LO or WR_HI SHALL abort the op with no further writes; the first edge after deassertion SHALL see in_ready=1.

Configuration
REQ-027 Macro MULL_FLAGS_EN, when defined, SHALL make the block compute N and Z itself.
  - Long op: N = ResultExtra[31]; Z = ({ResultExtra, Result} == 0).
  - Single-write op: N = Result[31]; Z = (Result == 0).
  - C and V SHALL be preserved.
REQ-028 Without MULL_FLAGS_EN, Flags SHALL load the captured ALUFlags[3:2] into N and Z, and SHALL preserve C and V.

Structure
REQ-029 Shared package mull_pkg SHALL hold the state encoding and the op-code constants OP_MUL=100, OP_SMULL=110, OP_UMULL=111.
REQ-030 One combinational sub-module, mull_flag_gen, SHALL compute N/Z from a 64-bit value plus a long-op bit; it is instantiated only under MULL_FLAGS_EN.

Verification
REQ-031 MUL, A=-2 x B=3: Result=FFFFFFFA, RdLo=3, SetFlags=1 -> one write r3=FFFFFFFA; then IDLE; Flags N=1, Z=0.
REQ-032 SMULL, -5 x 10: lo=FFFFFFCE, hi=FFFFFFFF, RdLo=1, RdHi=2 -> r1=FFFFFFCE in cycle 1, r2=FFFFFFFF in cycle 2; Stall=1 in cycle 1 if in_valid stays high.
REQ-033 UMULL, 10 x 45: lo=000001C2, hi=0, SetFlags=1 under MULL_FLAGS_EN -> two writes; Flags N=0, Z=0, C and V unchanged.
REQ-034 Back-to-back: a MUL presented during WR_HI of an SMULL -> accepted that cycle; its write occurs in the next cycle with no bubble.
REQ-035 RdLo=RdHi=5 on UMULL with hi=00000007 -> two writes to r5, the last being 00000007.
REQ-036 Reset asserted in WR_LO of a long op -> RegWrite=0 immediately, no WR_HI write, Flags=0000.
